prg_loader: RTL

//  Framed serial programming sequencer for the 16 KB BIOS ROM write port.

---
 rtl/prg_loader_if.sv | 21 ++
 rtl/prg_loader.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/prg_loader_if.sv
// Byte stream from the serial receiver into the loader, and the ROM write port out of it.
// rx_valid and prg_wren are 1-cycle strobes with no back-pressure: data is qualified only while its strobe is high.
interface prg_loader_if #(
  parameter int ADDR_W = 14
);
  logic [7:0]        rx_byte;
  logic              rx_valid;
  logic [ADDR_W-1:0] prg_addr;
  logic [7:0]        prg_data;
  logic              prg_wren;

  modport master (
    output rx_byte, rx_valid,
    input  prg_addr, prg_data, prg_wren
  );

  modport slave (
    input  rx_byte, rx_valid,
    output prg_addr, prg_data, prg_wren
  );
endinterface

// File: rtl/prg_loader.sv
// Framed serial loader for the BIOS ROM write port: parses SYNC/CMD/ADDR/LEN/DATA/CSUM,
// writes data bytes, holds the CPU in reset during the frame and for RESET_HOLD cycles after it.
module prg_loader #(
  parameter int          ADDR_W     = 14,
  parameter logic [7:0]  SYNC       = 8'hA5,
  parameter int          TIMEOUT    = 1000000,
  parameter int          RESET_HOLD = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  prg_loader_if.slave  bus,
  output logic         cpu_reset,
  output logic         busy,
  output logic         frame_ok,
  output logic         frame_err,
  output logic [1:0]   err_code,
  output logic [3:0]   state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_CMD    = 4'd1,
    S_ADDR_L = 4'd2,
    S_ADDR_H = 4'd3,
    S_LEN_L  = 4'd4,
    S_LEN_H  = 4'd5,
    S_DATA   = 4'd6,
    S_CSUM   = 4'd7,
    S_HOLD   = 4'd8
  } state_t;

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int HD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [HD_W-1:0] HOLD_LAST = HD_W'(RESET_HOLD - 1);

  localparam logic [7:0] CMD_WRITE   = 8'h01;
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CMD     = 2'b01;
  localparam logic [1:0] ERR_CSUM    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  state_t            state_q, state_d;
  logic [7:0]        sum_q;
  logic [ADDR_W-1:0] base_q;
  logic [15:0]       len_q;
  logic [15:0]       idx_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic [HD_W-1:0]   hold_cnt_q;
  logic              cpu_reset_q;
  logic [ADDR_W-1:0] prg_addr_q;
  logic [7:0]        prg_data_q;
  logic              prg_wren_q;
  logic              frame_ok_q;
  logic              frame_err_q;
  logic [1:0]        err_code_q;

  logic       rx;
  logic [7:0] rx_b;
  logic [7:0] sum_next;
  logic [15:0] idx_next;
  logic [15:0] len_full;
  logic       in_frame;
  logic       timeout_hit;
  logic       cmd_good;
  logic       cmd_bad;
  logic       csum_end;
  logic       csum_good;
  logic       abort;
  logic [1:0] abort_code;

  // Output-decode signals
  logic wr_fire;
  logic ok_fire;
  logic err_fire;
  logic hold_done;

  assign rx       = bus.rx_valid;
  assign rx_b     = bus.rx_byte;
  assign sum_next = sum_q + rx_b;
  assign idx_next = idx_q + 16'd1;
  assign len_full = {rx_b, len_q[7:0]};
  assign in_frame = (state_q != S_IDLE) && (state_q != S_HOLD);

  // A byte arriving on the last allowed cycle clears the counter instead of aborting.
  assign timeout_hit = in_frame && !rx && (to_cnt_q == TO_LAST);
  assign cmd_good    = (state_q == S_CMD) && rx && (rx_b == CMD_WRITE);
  assign cmd_bad     = (state_q == S_CMD) && rx && (rx_b != CMD_WRITE);
  assign csum_end    = (state_q == S_CSUM) && rx;
  assign csum_good   = csum_end && (sum_next == 8'h00);
  assign abort       = cmd_bad || (csum_end && !csum_good) || timeout_hit;

  always_comb begin
    abort_code = ERR_NONE;
    if (timeout_hit)   abort_code = ERR_TIMEOUT;
    else if (cmd_bad)  abort_code = ERR_CMD;
    else if (csum_end) abort_code = ERR_CSUM;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (rx && rx_b == SYNC) state_d = S_CMD;
      S_CMD:    if (cmd_good) state_d = S_ADDR_L;
      S_ADDR_L: if (rx) state_d = S_ADDR_H;
      S_ADDR_H: if (rx) state_d = S_LEN_L;
      S_LEN_L:  if (rx) state_d = S_LEN_H;
      S_LEN_H:  if (rx) state_d = (len_full == 16'd0) ? S_CSUM : S_DATA;
      S_DATA:   if (rx && idx_next == len_q) state_d = S_CSUM;
      S_CSUM:   if (rx) state_d = S_HOLD;
      S_HOLD:   if (hold_done) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    // Without a CPU reset in force there is nothing to hold off.
    if (abort) state_d = cpu_reset_q ? S_HOLD : S_IDLE;
  end

  // Output decode
  always_comb begin
    wr_fire   = (state_q == S_DATA) && rx;
    ok_fire   = csum_good;
    err_fire  = abort;
    hold_done = (state_q == S_HOLD) && (hold_cnt_q == HOLD_LAST);
    busy      = (state_q != S_IDLE);
    state_dbg = state_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sum_q       <= '0;
      base_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      to_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      cpu_reset_q <= 1'b0;
      prg_addr_q  <= '0;
      prg_data_q  <= '0;
      prg_wren_q  <= 1'b0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      prg_wren_q  <= wr_fire;
      frame_ok_q  <= ok_fire;
      frame_err_q <= err_fire;

      if (wr_fire) begin
        prg_addr_q <= base_q + idx_q[ADDR_W-1:0];
        prg_data_q <= rx_b;
        idx_q      <= idx_next;
      end

      if (cmd_good)             sum_q <= rx_b;
      else if (in_frame && rx)  sum_q <= sum_next;

      if (state_q == S_ADDR_L && rx) base_q[7:0] <= rx_b;
      // Address bits above ADDR_W in the high byte are dropped here.
      if (state_q == S_ADDR_H && rx) base_q <= ADDR_W'({rx_b, base_q[7:0]});
      if (state_q == S_LEN_L && rx)  len_q[7:0] <= rx_b;
      if (state_q == S_LEN_H && rx) begin
        len_q[15:8] <= rx_b;
        idx_q       <= 16'd0;
      end

      if (!in_frame || rx) to_cnt_q <= '0;
      else                 to_cnt_q <= to_cnt_q + TO_W'(1);

      if (state_q == S_HOLD && !hold_done) hold_cnt_q <= hold_cnt_q + HD_W'(1);
      else                                 hold_cnt_q <= '0;

      if (cmd_good)       cpu_reset_q <= 1'b1;
      else if (hold_done) cpu_reset_q <= 1'b0;

      if (abort)        err_code_q <= abort_code;
      else if (ok_fire) err_code_q <= ERR_NONE;
    end
  end

  assign bus.prg_addr = prg_addr_q;
  assign bus.prg_data = prg_data_q;
  assign bus.prg_wren = prg_wren_q;
  assign cpu_reset    = cpu_reset_q;
  assign frame_ok     = frame_ok_q;
  assign frame_err    = frame_err_q;
  assign err_code     = err_code_q;

endmodule
